// File: rtl/sbox_share_sched.sv
// ============================================================================
// Module   : sbox_share_sched
// Purpose  : Shares one 32-bit SubWord slice between a 4-beat SubBytes
//            requester and a 1-beat key SubWord requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox_share_sched #(
  parameter int KEY_PRIORITY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_in,
  output logic         st_out_valid,
  output logic [127:0] st_out,
  input  logic         kw_req_valid,
  output logic         kw_req_ready,
  input  logic [31:0]  kw_in,
  output logic         kw_out_valid,
  output logic [31:0]  kw_out,
  output logic         busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic KEY_WINS = (KEY_PRIORITY != 0);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Inverse as a^254 (chain of squarings), then the affine transform
  function automatic logic [7:0] sub_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    cnt;
  logic          last_key;
  logic [95:0]   st_buf;
  logic [31:0]   slice_in;
  logic [31:0]   slice_out;
  logic          idle;
  logic          grant_key;

  assign idle = (state == IDLE);
  assign busy = (state == ST_BUSY);

  // A lone key wins; on a tie it wins under priority or when state went last
  always_comb begin
    grant_key    = kw_req_valid & (~st_req_valid | KEY_WINS | ~last_key);
    kw_req_ready = idle & grant_key;
    st_req_ready = idle & st_req_valid & ~grant_key;
  end

  always_comb begin
    slice_in = st_in[127:96];
    if (idle) begin
      if (grant_key) slice_in = kw_in;
    end else begin
      case (cnt)
        2'd1:    slice_in = st_buf[95:64];
        2'd2:    slice_in = st_buf[63:32];
        2'd3:    slice_in = st_buf[31:0];
        default: slice_in = st_buf[95:64];
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign slice_out[8*g +: 8] = sub_byte(slice_in[8*g +: 8]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (st_req_ready) state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= 2'd0;
      last_key     <= 1'b1;
      st_buf       <= '0;
      st_out       <= '0;
      kw_out       <= '0;
      st_out_valid <= 1'b0;
      kw_out_valid <= 1'b0;
    end else begin
      st_out_valid <= 1'b0;
      kw_out_valid <= 1'b0;
      if (idle) begin
        if (kw_req_ready) begin
          kw_out       <= slice_out;
          kw_out_valid <= 1'b1;
          last_key     <= 1'b1;
        end else if (st_req_ready) begin
          st_buf          <= st_in[95:0];
          st_out[127:96]  <= slice_out;
          cnt             <= 2'd1;
          last_key        <= 1'b0;
        end
      end else begin
        case (cnt)
          2'd1:    st_out[95:64] <= slice_out;
          2'd2:    st_out[63:32] <= slice_out;
          2'd3:    st_out[31:0]  <= slice_out;
          default: ;
        endcase
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) st_out_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sbox_share_sched.sv
// ============================================================================
// Module   : tb_sbox_share_sched
// Purpose  : Self-checking bench for sbox_share_sched against a table S-box.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sbox_share_sched;

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct {
    logic         is_key;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_v, st_rdy, st_ov, kw_v, kw_rdy, kw_ov, busy;
  logic [127:0] st_in, st_out;
  logic [31:0]  kw_in, kw_out;
  logic         st_v_p, st_rdy_p, st_ov_p, kw_v_p, kw_rdy_p, kw_ov_p, busy_p;
  logic [127:0] st_in_p, st_out_p;
  logic [31:0]  kw_in_p, kw_out_p;

  int checks = 0;
  int errors = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  sbox_share_sched #(.KEY_PRIORITY(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(st_v), .st_req_ready(st_rdy), .st_in(st_in),
    .st_out_valid(st_ov), .st_out(st_out),
    .kw_req_valid(kw_v), .kw_req_ready(kw_rdy), .kw_in(kw_in),
    .kw_out_valid(kw_ov), .kw_out(kw_out), .busy(busy)
  );

  sbox_share_sched #(.KEY_PRIORITY(1)) dut_kp (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(st_v_p), .st_req_ready(st_rdy_p), .st_in(st_in_p),
    .st_out_valid(st_ov_p), .st_out(st_out_p),
    .kw_req_valid(kw_v_p), .kw_req_ready(kw_rdy_p), .kw_in(kw_in_p),
    .kw_out_valid(kw_ov_p), .kw_out(kw_out_p), .busy(busy_p)
  );

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    int idx;
    row = SBOX_ROWS[x[7:4]];
    idx = 15 - int'(x[3:0]);
    return row[8*idx +: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(x[8*i +: 8]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    st_v = 1'b0; kw_v = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    if (v.is_key) begin kw_v = 1'b1; kw_in = v.din[31:0]; end
    else          begin st_v = 1'b1; st_in = v.din;       end
    @(negedge clk);
    if (v.is_key) chk("vec_kw_ready", kw_rdy, 1'b1);
    else          chk("vec_st_ready", st_rdy, 1'b1);
    @(posedge clk); #1 kw_v = 1'b0; st_v = 1'b0;
    if (v.is_key) begin
      @(negedge clk);
      chk("vec_kw_valid", kw_ov, 1'b1);
      chk("vec_kw_out", kw_out, v.dout);
      @(negedge clk);
      chk("vec_kw_valid_drop", kw_ov, 1'b0);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        chk("vec_busy", busy, k < 4);
        chk("vec_st_valid", st_ov, k == 4);
      end
      chk("vec_st_out", st_out, v.dout);
      @(negedge clk);
      chk("vec_st_valid_drop", st_ov, 1'b0);
    end
  endtask

  initial begin
    int cyc, m_busy;
    logic m_last_key, pred_k, pred_s;
    logic kw_pend, st_pend;
    int kw_due, st_due;
    logic [31:0] kw_exp;
    logic [127:0] st_exp;

    vecs[0] = '{1'b1, 128'h0, 128'h63636363};
    vecs[1] = '{1'b1, 128'h53ff0001, 128'hed16637c};
    vecs[2] = '{1'b1, 128'h01020304, 128'h7c777bf2};
    vecs[3] = '{1'b1, 128'hffffffff, 128'h16161616};
    vecs[4] = '{1'b0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[5] = '{1'b0, 128'h0, {16{8'h63}}};
    vecs[6] = '{1'b1, 128'h10203040, 128'hcab70409};

    rst_n = 1'b0;
    st_v = 1'b0; kw_v = 1'b0; st_in = '0; kw_in = '0;
    st_v_p = 1'b0; kw_v_p = 1'b0; st_in_p = '0; kw_in_p = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_st_out", st_out, 128'h0);
    chk("rst_kw_out", kw_out, 32'h0);
    chk("rst_valids", {st_ov, kw_ov, busy}, 3'b000);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {st_rdy, kw_rdy, st_ov, kw_ov, busy}, 5'b0);

    // First tie after reset goes to state; the waiting key wins on completion
    @(posedge clk); #1;
    st_v = 1'b1; st_in = vecs[4].din; kw_v = 1'b1; kw_in = 32'h53ff0001;
    @(negedge clk);
    chk("tie_st_first", {st_rdy, kw_rdy}, 2'b10);
    @(posedge clk); #1 st_v = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("tie_kw_ready", kw_rdy, k == 4);
      chk("tie_st_valid", st_ov, k == 4);
    end
    chk("tie_st_out", st_out, vecs[4].dout);
    @(posedge clk); #1 kw_v = 1'b0;
    @(negedge clk);
    chk("tie_kw_valid", kw_ov, 1'b1);
    chk("tie_kw_out", kw_out, 32'hed16637c);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back state requests: one accept and one result every 4 cycles
    @(posedge clk); #1 st_v = 1'b1; st_in = vecs[4].din;
    @(negedge clk);
    chk("b2b_first", st_rdy, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("b2b_ready", st_rdy, (k % 4) == 0);
      chk("b2b_valid", st_ov, (k % 4) == 0);
      if ((k % 4) == 0) chk("b2b_out", st_out, vecs[4].dout);
    end
    @(posedge clk); #1 st_v = 1'b0;
    repeat (4) @(negedge clk);

    // Abort a transfer with reset while cnt=2
    @(posedge clk); #1 st_v = 1'b1; st_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    @(negedge clk);
    @(posedge clk); #1 st_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_st_out", st_out, 128'h0);
    chk("abort_kw_out", kw_out, 32'h0);
    chk("abort_flags", {st_ov, kw_ov, busy}, 3'b000);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_valid", st_ov, 1'b0);
    end
    run_vec(vecs[4]);

    // Randomized traffic against the scoreboard
    do_reset();
    cyc = 0; m_busy = 0; m_last_key = 1'b1;
    kw_pend = 1'b0; st_pend = 1'b0; kw_due = 0; st_due = 0;
    kw_exp = '0; st_exp = '0;
    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      chk("rnd_kw_valid", kw_ov, kw_pend && kw_due == cyc);
      if (kw_pend && kw_due == cyc) begin
        chk("rnd_kw_out", kw_out, kw_exp);
        kw_pend = 1'b0;
      end
      chk("rnd_st_valid", st_ov, st_pend && st_due == cyc);
      if (st_pend && st_due == cyc) begin
        chk("rnd_st_out", st_out, st_exp);
        st_pend = 1'b0;
      end
      chk("rnd_busy", busy, m_busy > 0);
      chk("rnd_both_ready", st_rdy & kw_rdy, 1'b0);
      pred_k = (m_busy == 0) && kw_v && (!st_v || !m_last_key);
      pred_s = (m_busy == 0) && st_v && !pred_k;
      chk("rnd_kw_ready", kw_rdy, pred_k);
      chk("rnd_st_ready", st_rdy, pred_s);
      if (pred_k) begin
        kw_pend = 1'b1; kw_due = cyc + 1; m_last_key = 1'b1;
        for (int b = 0; b < 4; b++) kw_exp[8*b +: 8] = sbox(kw_in[8*b +: 8]);
      end
      if (pred_s) begin
        st_pend = 1'b1; st_due = cyc + 4; st_exp = sub_bytes(st_in);
        m_last_key = 1'b0; m_busy = 3;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      @(posedge clk); #1;
      if (!(st_v && !pred_s)) begin
        st_v  = (it < 580) && ($urandom_range(0, 2) != 0);
        st_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (!(kw_v && !pred_k)) begin
        kw_v  = (it < 580) && ($urandom_range(0, 1) != 0);
        kw_in = $urandom();
      end
      cyc++;
    end
    chk("rnd_drain", {kw_pend, st_pend}, 2'b00);

    // KEY_PRIORITY=1: key wins every tie while held
    @(posedge clk); #1;
    st_v_p = 1'b1; st_in_p = vecs[4].din; kw_v_p = 1'b1; kw_in_p = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("kp_kw_ready", kw_rdy_p, 1'b1);
      chk("kp_st_ready", st_rdy_p, 1'b0);
      chk("kp_busy", busy_p, 1'b0);
      if (k > 0) chk("kp_kw_out", {kw_ov_p, kw_out_p}, {1'b1, 32'h63636363});
    end
    @(posedge clk); #1 kw_v_p = 1'b0;
    @(negedge clk);
    chk("kp_st_ready_alone", st_rdy_p, 1'b1);
    @(posedge clk); #1 st_v_p = 1'b0;
    repeat (4) @(negedge clk);
    chk("kp_st_out", {st_ov_p, st_out_p}, {1'b1, vecs[4].dout});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
